// File: rtl/i2s_deser_pkg.sv
// Shared types and helpers for the I2S receiver.
package i2s_deser_pkg;

    typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_t;

    typedef enum logic {ST_HUNT = 1'b0, ST_RUN = 1'b1} i2s_rx_state_t;

    localparam int unsigned SYNC_STAGES = 2;

    // Width of a counter that must reach w inclusive.
    function automatic int unsigned cnt_bits(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/i2s_deser_if.sv
// Serial I2S lines plus the recovered parallel sample pair.
interface i2s_deser_if #(
    parameter int unsigned w_ser = 16
);
    logic             bclk;
    logic             lrclk;
    logic             sd;
    logic [w_ser-1:0] out_l;
    logic [w_ser-1:0] out_r;
    logic             out_valid;
    logic             slot_err;

    modport master (
        output bclk, lrclk, sd,
        input  out_l, out_r, out_valid, slot_err
    );

    modport slave (
        input  bclk, lrclk, sd,
        output out_l, out_r, out_valid, slot_err
    );
endinterface

// File: rtl/i2s_deser_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
module i2s_deser_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/i2s_deser.sv
// I2S / PT8211-style receiver: oversamples BCLK/LRCLK/SD in the clk domain
// and emits one left/right sample pair per frame.
module i2s_deser
    import i2s_deser_pkg::*;
#(
    parameter int unsigned w_ser               = 16,
    parameter bit          align_right         = 1'b0,
    parameter bit          offset_by_one_cycle = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    i2s_deser_if.slave i2s
);
    localparam int unsigned      CNT_W    = cnt_bits(w_ser);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(w_ser);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic bclk_s;
    logic lrclk_s;
    logic sd_s;

    i2s_deser_sync_2ff u_sync_bclk  (.clk(clk), .rst(rst), .d_i(i2s.bclk),  .q_o(bclk_s));
    i2s_deser_sync_2ff u_sync_lrclk (.clk(clk), .rst(rst), .d_i(i2s.lrclk), .q_o(lrclk_s));
    i2s_deser_sync_2ff u_sync_sd    (.clk(clk), .rst(rst), .d_i(i2s.sd),    .q_o(sd_s));

    i2s_rx_state_t    state_q, state_d;
    i2s_ch_t          ch_prev_q;
    logic             bclk_prev_q;
    logic             ws_q;
    logic [w_ser-1:0] shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic [w_ser-1:0] l_hold_q;
    logic             l_have_q;
    logic [w_ser-1:0] out_l_q;
    logic [w_ser-1:0] out_r_q;
    logic             out_valid_q;
    logic             slot_err_q;

    logic    edge_c;
    i2s_ch_t ch_c;
    logic    boundary_c;

    // Standard I2S lags the channel by one bit, so use LRCLK from the previous edge.
    assign edge_c     = bclk_s & ~bclk_prev_q;
    assign ch_c       = i2s_ch_t'(offset_by_one_cycle ? ws_q : lrclk_s);
    assign boundary_c = edge_c && (ch_c != ch_prev_q);

    always_comb begin
        state_d = state_q;
        if ((state_q == ST_HUNT) && boundary_c) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            ch_prev_q   <= CH_LEFT;
            bclk_prev_q <= 1'b0;
            ws_q        <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            l_hold_q    <= '0;
            l_have_q    <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            slot_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bclk_prev_q <= bclk_s;
            out_valid_q <= 1'b0;
            slot_err_q  <= 1'b0;
            if (edge_c) begin
                ws_q      <= lrclk_s;
                ch_prev_q <= ch_c;
                if (boundary_c) begin
                    // Commit the finished slot, then start the new one with this bit.
                    if (state_q == ST_RUN) begin
                        if (cnt_q < CNT_FULL) begin
                            slot_err_q <= 1'b1;
                            l_have_q   <= 1'b0;
                        end else if (ch_prev_q == CH_LEFT) begin
                            l_hold_q <= shift_q;
                            l_have_q <= 1'b1;
                        end else if (l_have_q) begin
                            out_l_q     <= l_hold_q;
                            out_r_q     <= shift_q;
                            out_valid_q <= 1'b1;
                            l_have_q    <= 1'b0;
                        end
                    end
                    shift_q <= w_ser'(sd_s);
                    cnt_q   <= CNT_ONE;
                end else if (state_q == ST_RUN) begin
                    if (align_right || (cnt_q < CNT_FULL)) begin
                        shift_q <= {shift_q[w_ser-2:0], sd_s};
                    end
                    if (cnt_q < CNT_FULL) begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            end
        end
    end

    assign i2s.out_l     = out_l_q;
    assign i2s.out_r     = out_r_q;
    assign i2s.out_valid = out_valid_q;
    assign i2s.slot_err  = slot_err_q;
endmodule

// File: tb/tb_i2s_deser.sv
// Bench for i2s_deser: three parameter variants share one serial stream and are
// checked against a slot-level reference model.
module tb_i2s_deser;
    localparam int unsigned W     = 16;
    localparam int          N_DUT = 3;

    typedef struct packed {
        logic [1:0]   dut;
        logic         is_err;
        logic [W-1:0] l;
        logic [W-1:0] r;
    } ev_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic bclk  = 1'b0;
    logic lrclk = 1'b0;
    logic sd    = 1'b0;

    always #5 clk = ~clk;

    i2s_deser_if #(.w_ser(W)) if0 ();
    i2s_deser_if #(.w_ser(W)) if1 ();
    i2s_deser_if #(.w_ser(W)) if2 ();

    assign if0.bclk = bclk;  assign if0.lrclk = lrclk;  assign if0.sd = sd;
    assign if1.bclk = bclk;  assign if1.lrclk = lrclk;  assign if1.sd = sd;
    assign if2.bclk = bclk;  assign if2.lrclk = lrclk;  assign if2.sd = sd;

    // dut0: defaults; dut1: LSB-justified PT8211; dut2: LSB-justified I2S
    i2s_deser #(.w_ser(W), .align_right(1'b0), .offset_by_one_cycle(1'b1))
        dut0 (.clk(clk), .rst(rst), .i2s(if0));
    i2s_deser #(.w_ser(W), .align_right(1'b1), .offset_by_one_cycle(1'b0))
        dut1 (.clk(clk), .rst(rst), .i2s(if1));
    i2s_deser #(.w_ser(W), .align_right(1'b1), .offset_by_one_cycle(1'b1))
        dut2 (.clk(clk), .rst(rst), .i2s(if2));

    logic [W-1:0] o_l [N_DUT];
    logic [W-1:0] o_r [N_DUT];
    logic         o_v [N_DUT];
    logic         o_e [N_DUT];

    assign o_l[0] = if0.out_l;  assign o_r[0] = if0.out_r;  assign o_v[0] = if0.out_valid;  assign o_e[0] = if0.slot_err;
    assign o_l[1] = if1.out_l;  assign o_r[1] = if1.out_r;  assign o_v[1] = if1.out_valid;  assign o_e[1] = if1.slot_err;
    assign o_l[2] = if2.out_l;  assign o_r[2] = if2.out_r;  assign o_v[2] = if2.out_valid;  assign o_e[2] = if2.slot_err;

    logic edge_lr [$];
    logic edge_sd [$];
    logic q_lr    [$];
    logic q_bits  [$];
    ev_t  act_q   [$];
    ev_t  exp_q   [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic bit dut_align(input int d);
        return d != 0;
    endfunction

    function automatic bit dut_offset(input int d);
        return d != 1;
    endfunction

    // Record every pulse of every DUT, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < N_DUT; d++) begin
                if (o_v[d] === 1'b1) act_q.push_back('{dut: 2'(d), is_err: 1'b0, l: o_l[d], r: o_r[d]});
                if (o_e[d] === 1'b1) act_q.push_back('{dut: 2'(d), is_err: 1'b1, l: '0, r: '0});
            end
        end
    end

    // Reference: split the logged edges into channel slots and apply the pairing rules.
    task automatic build_exp(input int d);
        logic         prev_lr, ch, ch_prev, running, l_have;
        logic [W-1:0] l_hold, word;
        logic         slot [$];
        int           base;
        exp_q.delete();
        prev_lr = 1'b0; ch_prev = 1'b0; running = 1'b0; l_have = 1'b0; l_hold = '0;
        slot.delete();
        for (int k = 0; k <= edge_lr.size(); k++) begin
            if (k == edge_lr.size()) break;
            ch      = dut_offset(d) ? prev_lr : edge_lr[k];
            prev_lr = edge_lr[k];
            if (ch != ch_prev) begin
                if (running) begin
                    if (slot.size() < int'(W)) begin
                        exp_q.push_back('{dut: 2'(d), is_err: 1'b1, l: '0, r: '0});
                        l_have = 1'b0;
                    end else begin
                        base = dut_align(d) ? slot.size() - int'(W) : 0;
                        word = '0;
                        for (int i = 0; i < int'(W); i++) word = {word[W-2:0], slot[base + i]};
                        if (ch_prev == 1'b0) begin
                            l_hold = word;
                            l_have = 1'b1;
                        end else if (l_have) begin
                            exp_q.push_back('{dut: 2'(d), is_err: 1'b0, l: l_hold, r: word});
                            l_have = 1'b0;
                        end
                    end
                end
                running = 1'b1;
                slot.delete();
                ch_prev = ch;
            end
            if (running) slot.push_back(edge_sd[k]);
        end
    endtask

    function automatic int first_diff(input int d);
        ev_t a [$];
        foreach (act_q[i]) if (act_q[i].dut == 2'(d)) a.push_back(act_q[i]);
        if (a.size() != exp_q.size()) return (a.size() < exp_q.size()) ? a.size() : exp_q.size();
        foreach (a[i]) if (a[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // kind: 0 = valid pulses, 1 = slot errors, 2 = both
    function automatic int count_ev(input int d, input int kind);
        int n = 0;
        foreach (act_q[i])
            if (act_q[i].dut == 2'(d) && (kind == 2 || int'(act_q[i].is_err) == kind)) n++;
        return n;
    endfunction

    function automatic ev_t nth_valid(input int d, input int n);
        ev_t v [$];
        foreach (act_q[i]) if (act_q[i].dut == 2'(d) && !act_q[i].is_err) v.push_back(act_q[i]);
        if (v.size() == 0) return '0;
        if (n < 0) return v[v.size()-1];
        if (n >= v.size()) return '0;
        return v[n];
    endfunction

    task automatic drive_bit(input logic lr, input logic b);
        bclk = 1'b0; lrclk = lr; sd = b;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        edge_lr.push_back(lr);
        edge_sd.push_back(b);
        repeat (4) @(negedge clk);
    endtask

    task automatic push_slot(input logic lr, input int len, input logic [31:0] data);
        for (int i = 0; i < len; i++) begin
            q_lr.push_back(lr);
            q_bits.push_back(data[len-1-i]);
        end
    endtask

    task automatic push_frame(input int len, input logic [31:0] l, input logic [31:0] r);
        push_slot(1'b0, len, l);
        push_slot(1'b1, len, r);
    endtask

    // off=1 delays SD by one bit relative to LRCLK (standard I2S framing).
    task automatic play(input bit off);
        logic prev_bit;
        prev_bit = 1'b0;
        for (int k = 0; k < q_lr.size(); k++) begin
            drive_bit(q_lr[k], off ? prev_bit : q_bits[k]);
            prev_bit = q_bits[k];
        end
        q_lr.delete();
        q_bits.delete();
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bclk = 1'b0; lrclk = 1'b0; sd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        edge_lr.delete(); edge_sd.delete(); act_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < N_DUT; d++) begin
            n_cmp++;
            if ({o_l[d], o_r[d], o_v[d], o_e[d]} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got l=%h r=%h v=%b e=%b, expected all zero", d, o_l[d], o_r[d], o_v[d], o_e[d]);
            end
        end
        do_reset();
    endtask

    task automatic test_msb_justified();
        ev_t e;
        int  idx;
        do_reset();
        for (int f = 0; f < 4; f++) push_frame(32, {16'hA5C3, 16'($urandom)}, {16'h0F0F, 16'($urandom)});
        push_slot(1'b0, 2, 32'h0);
        play(1'b1);
        e = nth_valid(0, -1);
        n_cmp++;
        if ({e.l, e.r} !== {16'hA5C3, 16'h0F0F}) begin
            n_bad++; $display("FAIL t1_pair dut0: got %h/%h, expected a5c3/0f0f", e.l, e.r);
        end
        n_cmp++;
        if (count_ev(0, 0) !== 3) begin
            n_bad++; $display("FAIL t1_valid_count dut0: got %0d, expected 3", count_ev(0, 0));
        end
        for (int d = 0; d < N_DUT; d++) begin
            build_exp(d); idx = first_diff(d); n_cmp++;
            if (idx !== -1) begin
                n_bad++; $display("FAIL t1_model dut%0d: differs at event %0d, got %0d events, expected %0d", d, idx, count_ev(d, 2), exp_q.size());
            end
        end
    endtask

    task automatic test_pt8211();
        ev_t e;
        int  idx;
        do_reset();
        for (int f = 0; f < 3; f++) push_frame(16, 32'h8001, 32'h7FFE);
        push_slot(1'b0, 1, 32'h0);
        play(1'b0);
        e = nth_valid(1, -1);
        n_cmp++;
        if ({e.l, e.r} !== {16'h8001, 16'h7FFE}) begin
            n_bad++; $display("FAIL t2_pair dut1: got %h/%h, expected 8001/7ffe", e.l, e.r);
        end
        n_cmp++;
        if (count_ev(1, 1) !== 0 || count_ev(1, 0) !== 2) begin
            n_bad++; $display("FAIL t2_counts dut1: got %0d errors %0d valids, expected 0 errors 2 valids", count_ev(1, 1), count_ev(1, 0));
        end
        for (int d = 0; d < N_DUT; d++) begin
            build_exp(d); idx = first_diff(d); n_cmp++;
            if (idx !== -1) begin
                n_bad++; $display("FAIL t2_model dut%0d: differs at event %0d, got %0d events, expected %0d", d, idx, count_ev(d, 2), exp_q.size());
            end
        end
    endtask

    task automatic test_long_slot();
        ev_t e0, e2;
        int  idx;
        do_reset();
        for (int f = 0; f < 3; f++) push_frame(24, 32'h0012_3456, 32'($urandom & 32'h00FF_FFFF));
        push_slot(1'b0, 2, 32'h0);
        play(1'b1);
        e2 = nth_valid(2, -1);
        e0 = nth_valid(0, -1);
        n_cmp++;
        if (e2.l !== 16'h3456) begin
            n_bad++; $display("FAIL t3_lsb_word dut2: got %h, expected 3456", e2.l);
        end
        n_cmp++;
        if (e0.l !== 16'h1234) begin
            n_bad++; $display("FAIL t3_msb_word dut0: got %h, expected 1234", e0.l);
        end
        for (int d = 0; d < N_DUT; d++) begin
            build_exp(d); idx = first_diff(d); n_cmp++;
            if (idx !== -1) begin
                n_bad++; $display("FAIL t3_model dut%0d: differs at event %0d, got %0d events, expected %0d", d, idx, count_ev(d, 2), exp_q.size());
            end
        end
    endtask

    task automatic test_short_slot();
        logic [31:0] l5, r5;
        ev_t e;
        int  idx;
        do_reset();
        push_frame(32, $urandom, $urandom);
        push_frame(32, $urandom, $urandom);
        push_slot(1'b0, 8, $urandom);
        push_slot(1'b1, 32, $urandom);
        push_frame(32, $urandom, $urandom);
        l5 = $urandom; r5 = $urandom;
        push_frame(32, l5, r5);
        push_slot(1'b0, 2, 32'h0);
        play(1'b1);
        n_cmp++;
        if (count_ev(0, 1) !== 1) begin
            n_bad++; $display("FAIL t4_err_count dut0: got %0d, expected 1", count_ev(0, 1));
        end
        n_cmp++;
        if (count_ev(0, 0) !== 3) begin
            n_bad++; $display("FAIL t4_valid_count dut0: got %0d, expected 3", count_ev(0, 0));
        end
        e = nth_valid(0, -1);
        n_cmp++;
        if ({e.l, e.r} !== {l5[31:16], r5[31:16]}) begin
            n_bad++; $display("FAIL t4_recover dut0: got %h/%h, expected %h/%h", e.l, e.r, l5[31:16], r5[31:16]);
        end
        for (int d = 0; d < N_DUT; d++) begin
            build_exp(d); idx = first_diff(d); n_cmp++;
            if (idx !== -1) begin
                n_bad++; $display("FAIL t4_model dut%0d: differs at event %0d, got %0d events, expected %0d", d, idx, count_ev(d, 2), exp_q.size());
            end
        end
    endtask

    task automatic test_mid_reset();
        ev_t e;
        int  idx;
        do_reset();
        push_frame(32, $urandom, $urandom);
        push_frame(32, {16'hC0DE, 16'($urandom)}, $urandom);
        push_slot(1'b0, 32, $urandom);
        push_slot(1'b1, 16, $urandom);
        play(1'b1);
        n_cmp++;
        if (o_l[0] !== 16'hC0DE) begin
            n_bad++; $display("FAIL t5_pre_reset dut0: got out_l=%h, expected c0de", o_l[0]);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            n_cmp++;
            if ({o_l[d], o_r[d], o_v[d], o_e[d]} !== '0) begin
                n_bad++;
                $display("FAIL t5_async_reset dut%0d: got l=%h r=%h v=%b e=%b, expected all zero", d, o_l[d], o_r[d], o_v[d], o_e[d]);
            end
        end
        bclk = 1'b0; lrclk = 1'b0; sd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        edge_lr.delete(); edge_sd.delete(); act_q.delete();
        repeat (2) @(negedge clk);
        push_slot(1'b1, 16, $urandom);
        push_frame(32, {16'h1357, 16'($urandom)}, {16'h2468, 16'($urandom)});
        push_frame(32, $urandom, $urandom);
        push_slot(1'b0, 2, 32'h0);
        play(1'b1);
        e = nth_valid(0, 0);
        n_cmp++;
        if ({e.l, e.r} !== {16'h1357, 16'h2468}) begin
            n_bad++; $display("FAIL t5_first_pair dut0: got %h/%h, expected 1357/2468", e.l, e.r);
        end
        for (int d = 0; d < N_DUT; d++) begin
            build_exp(d); idx = first_diff(d); n_cmp++;
            if (idx !== -1) begin
                n_bad++; $display("FAIL t5_model dut%0d: differs at event %0d, got %0d events, expected %0d", d, idx, count_ev(d, 2), exp_q.size());
            end
        end
    endtask

    task automatic test_start_mid_right();
        ev_t e;
        int  idx;
        do_reset();
        push_slot(1'b1, 10, $urandom);
        push_frame(32, {16'h5A5A, 16'($urandom)}, {16'hA5A5, 16'($urandom)});
        push_frame(32, $urandom, $urandom);
        push_slot(1'b0, 2, 32'h0);
        play(1'b1);
        e = nth_valid(0, 0);
        n_cmp++;
        if ({e.l, e.r} !== {16'h5A5A, 16'hA5A5}) begin
            n_bad++; $display("FAIL t6_first_pair dut0: got %h/%h, expected 5a5a/a5a5", e.l, e.r);
        end
        n_cmp++;
        if (count_ev(0, 0) !== 2) begin
            n_bad++; $display("FAIL t6_valid_count dut0: got %0d, expected 2", count_ev(0, 0));
        end
        for (int d = 0; d < N_DUT; d++) begin
            build_exp(d); idx = first_diff(d); n_cmp++;
            if (idx !== -1) begin
                n_bad++; $display("FAIL t6_model dut%0d: differs at event %0d, got %0d events, expected %0d", d, idx, count_ev(d, 2), exp_q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_justified();
        test_pt8211();
        test_long_slot();
        test_short_slot();
        test_mid_reset();
        test_start_mid_right();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
